spi_flash_rd_seq: RTL and testbench
===================================

Name: spi_flash_rd_seq

Overview:
APB-master sequencer that performs a complete serial-flash READ (cmd 0x03 + 24-bit address + N data bytes) by programming the SPI controller's register file over its APB slave port. It sits between a simple request/stream client (boot loader, DMA) and the SPI controller and owns that controller while busy. It handles controller enable, software chip-select, one byte per transfer (write TXDATA, poll SPSR, read RXDATA), poll timeout and chip-select release.

Parameters:
SPCR_VAL, 8'h50, value written to SPCR (addr 0) at start; spe=1, mode 0, spr=00
SPER_VAL, 8'h00, value written to SPER (addr 3) at start
CS_IDX, 1, chip select used, legal 1..3
RD_CMD, 8'h03, flash read opcode
POLL_MAX, 1023, max SPSR polls per byte before timeout, 16-bit

Ports:
apb_pclk  in  1  clock
apb_prst  in  1  synchronous reset, active-high
req  in  1  start pulse, sampled only in IDLE
req_addr  in  24  flash byte address, latched on accepted req
req_len  in  8  byte count, 0 means 256, latched on accepted req
busy  out  1  high from cycle after accepted req until done
rd_data  out  8  received data byte
rd_valid  out  1  1-cycle strobe, rd_data valid
done  out  1  1-cycle completion strobe
err  out  1  valid with done: 1 = poll timeout
m_psel  out  1  APB select to SPI controller
m_penable  out  1  APB enable
m_pwrite  out  1  APB write
m_paddr  out  4  APB register address
m_pwdata  out  8  APB write data
m_prdata  in  8  APB read data

Behaviour:
- Reset (apb_prst=1 at clock edge): state IDLE; all outputs 0; counters cleared. Mid-operation reset aborts immediately: m_psel=0 next cycle, no CS-off write.
- APB op: 3 cycles, always: S (psel=1,penable=0), A (psel=1,penable=1), G (psel=0,penable=0). paddr/pwrite/pwdata stable over S and A. Read data sampled from m_prdata in G, because the slave registers its bus inputs. The next op's S may follow G directly.
- States and transitions:
  - IDLE --req--> CFG_SPCR. Latch address and len.
  - CFG_SPCR: write (0, SPCR_VAL).
  - CFG_SPER: write (3, SPER_VAL).
  - CS_ON: write (5, softcs), where softcs[3:0]=1<<CS_IDX and softcs[7:4]=~(1<<CS_IDX). CS_IDX=1 gives 8'hD2.
  - TX_WR: write (2, txbyte).
  - POLL: read addr 1. If bit0 (rfempty)=0, go to RX_RD. Otherwise poll count+1 and repeat. When count reaches POLL_MAX, go to CS_OFF with err_r=1.
  - RX_RD: read addr 2. If the byte index is 4 or more, rd_data=m_prdata and rd_valid=1 in G. Then either go back to TX_WR or, on the last byte, go to CS_OFF.
  - CS_OFF: write (5, 8'hF0).
  - DONE: done=1 and err=err_r for 1 cycle; busy drops the same cycle; then IDLE.
- txbyte by byte index: 0=RD_CMD, 1=addr[23:16], 2=addr[15:8], 3=addr[7:0], 4 and above=8'h00 (dummy).
- Header RX bytes (index 0..3) are discarded.
- Byte index is 9 bits. Total bytes = 4 + (req_len==0 ? 256 : req_len). Poll counter clears on each TX_WR.
- req while busy: ignored, not queued.
- The timeout path still releases CS (CS_OFF write) before DONE.
- Minimum per-byte cost: 9 cycles (TX 3 + one POLL 3 + RX 3).
- SPCR is not rewritten at end; the controller stays enabled.

Test Plan:
- req_addr=24'h123456, req_len=1, slave model echoes ~MOSI. Required APB writes, in order: (0,50),(3,00),(5,D2),(2,03),(2,12),(2,34),(2,56),(2,00),(5,F0). Each TX is followed by poll+read. Exactly one rd_valid with rd_data=8'hFF, then done=1, err=0.
- Model holds rfempty=1 for 3 polls per byte, len=2, data A5,5A. Required: 3 POLL ops with no advance, then 2 rd_valid strobes A5 then 5A. Header bytes never produce rd_valid.
- req_len=0 -> exactly 256 rd_valid strobes and 260 TXDATA writes before (5,F0); done asserted once.
- POLL_MAX=4, model never clears rfempty. Required: exactly 4 SPSR reads after the first TXDATA write, then (5,F0), then done=1 with err=1, zero rd_valid.
- Second req pulse during busy: no restart, only one done. req in the cycle after done: accepted, busy=1 next cycle.
- apb_prst=1 during POLL: next cycle m_psel=0, busy=0, done=0. A new req then starts cleanly with (0,50).

Source files
------------

// File: rtl/spi_flash_rd_seq.sv
// spi_flash_rd_seq: APB-master sequencer running a serial-flash READ (cmd + 24-bit addr + N bytes) through an SPI controller
module spi_flash_rd_seq #(
    parameter logic [7:0]  SPCR_VAL = 8'h50,
    parameter logic [7:0]  SPER_VAL = 8'h00,
    parameter int          CS_IDX   = 1,
    parameter logic [7:0]  RD_CMD   = 8'h03,
    parameter logic [15:0] POLL_MAX = 16'd1023
) (
    input  logic        apb_pclk,
    input  logic        apb_prst,
    input  logic        req,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_len,
    output logic        busy,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic        err,
    output logic        m_psel,
    output logic        m_penable,
    output logic        m_pwrite,
    output logic [3:0]  m_paddr,
    output logic [7:0]  m_pwdata,
    input  logic [7:0]  m_prdata
);
    typedef enum logic [3:0] {IDLE, CFG_SPCR, CFG_SPER, CS_ON, TX_WR, POLL, RX_RD, CS_OFF, DONE} state_t;
    localparam logic [3:0] CS_1H  = 4'(1 << CS_IDX);
    localparam logic [7:0] SOFTCS = {~CS_1H, CS_1H};
    state_t state, state_nxt;
    logic [1:0]  ph;
    logic [8:0]  idx;
    logic [8:0]  last_idx;
    logic [15:0] poll_cnt;
    logic [23:0] addr_r;
    logic [7:0]  len_r;
    logic [7:0]  txbyte;
    logic        err_r;
    logic        op;
    logic        op_end;
    logic        timeout;
    assign op       = state != IDLE && state != DONE;
    assign op_end   = ph == 2'd2;
    assign last_idx = (len_r == 8'd0 ? 9'd256 : {1'b0, len_r}) + 9'd3;
    assign timeout  = m_prdata[0] && poll_cnt == POLL_MAX - 16'd1;
    assign txbyte   = idx == 9'd0 ? RD_CMD :
                      idx == 9'd1 ? addr_r[23:16] :
                      idx == 9'd2 ? addr_r[15:8] :
                      idx == 9'd3 ? addr_r[7:0] : 8'h00;
    always_ff @(posedge apb_pclk) begin
        if (apb_prst)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = req ? CFG_SPCR : IDLE;
            CFG_SPCR: state_nxt = op_end ? CFG_SPER : state;
            CFG_SPER: state_nxt = op_end ? CS_ON : state;
            CS_ON:    state_nxt = op_end ? TX_WR : state;
            TX_WR:    state_nxt = op_end ? POLL : state;
            POLL:     state_nxt = !op_end ? state : !m_prdata[0] ? RX_RD : timeout ? CS_OFF : POLL;
            RX_RD:    state_nxt = !op_end ? state : idx == last_idx ? CS_OFF : TX_WR;
            CS_OFF:   state_nxt = op_end ? DONE : state;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end
    // ph walks S/A/G inside every bus-owning state and restarts on each op
    always_ff @(posedge apb_pclk) begin
        if (apb_prst) begin
            ph       <= 2'd0;
            idx      <= 9'd0;
            poll_cnt <= 16'd0;
            addr_r   <= 24'd0;
            len_r    <= 8'd0;
            err_r    <= 1'b0;
        end else begin
            ph <= op && !op_end ? ph + 2'd1 : 2'd0;
            if (state == IDLE && req) begin
                addr_r <= req_addr;
                len_r  <= req_len;
                idx    <= 9'd0;
                err_r  <= 1'b0;
            end
            if (state == TX_WR)
                poll_cnt <= 16'd0;
            if (state == POLL && op_end) begin
                poll_cnt <= poll_cnt + 16'd1;
                if (timeout)
                    err_r <= 1'b1;
            end
            if (state == RX_RD && op_end)
                idx <= idx + 9'd1;
        end
    end
    always_comb begin
        m_psel    = op && !op_end;
        m_penable = op && ph == 2'd1;
        m_pwrite  = state inside {CFG_SPCR, CFG_SPER, CS_ON, TX_WR, CS_OFF};
        m_paddr   = 4'd0;
        m_pwdata  = 8'h00;
        case (state)
            CFG_SPCR: m_pwdata = SPCR_VAL;
            CFG_SPER: begin m_paddr = 4'd3; m_pwdata = SPER_VAL; end
            CS_ON:    begin m_paddr = 4'd5; m_pwdata = SOFTCS; end
            TX_WR:    begin m_paddr = 4'd2; m_pwdata = txbyte; end
            POLL:     m_paddr = 4'd1;
            RX_RD:    m_paddr = 4'd2;
            CS_OFF:   begin m_paddr = 4'd5; m_pwdata = 8'hF0; end
            default:  m_paddr = 4'd0;
        endcase
        busy     = op;
        done     = state == DONE;
        err      = state == DONE && err_r;
        rd_valid = state == RX_RD && op_end && idx >= 9'd4;
        rd_data  = rd_valid ? m_prdata : 8'h00;
    end
endmodule

// File: tb/tb_spi_flash_rd_seq.sv
// tb_spi_flash_rd_seq: directed checks of the flash read sequencer against a behavioural SPI controller model
module tb_spi_flash_rd_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [23:0] req_addr = 24'd0;
    logic [7:0]  req_len = 8'd0;
    logic [7:0]  m_prdata = 8'd0;
    logic        use1 = 1'b0;
    logic        busy0, rv0, done0, err0, psel0, pen0, pwr0;
    logic        busy1, rv1, done1, err1, psel1, pen1, pwr1;
    logic [7:0]  rd0, pwd0, rd1, pwd1;
    logic [3:0]  pa0, pa1;
    logic        psel, pen, pwr, busy, rv, done, err;
    logic [3:0]  pa;
    logic [7:0]  pwd, rd;
    int          nchk = 0;
    int          nerr = 0;
    int          hold = 0;
    logic        never = 1'b0;
    logic        use_tab = 1'b0;
    logic [7:0]  tab [0:7];
    int          tx_n = 0;
    int          polls = 0;
    logic [7:0]  last_tx = 8'd0;
    int          nw = 0, ntx = 0, nspsr = 0, nrx = 0, nspcr = 0, nrv = 0, ndone = 0, ntx_f0 = 0;
    logic [11:0] wl [0:1023];
    logic [7:0]  rvd [0:1023];
    int          rvtx [0:1023];
    logic [11:0] exp1 [0:8] = '{12'h050, 12'h300, 12'h5D2, 12'h203, 12'h212, 12'h234, 12'h256, 12'h200, 12'h5F0};

    always #5 clk = ~clk;

    spi_flash_rd_seq dut0 (
        .apb_pclk(clk), .apb_prst(rst), .req(req0), .req_addr(req_addr), .req_len(req_len),
        .busy(busy0), .rd_data(rd0), .rd_valid(rv0), .done(done0), .err(err0),
        .m_psel(psel0), .m_penable(pen0), .m_pwrite(pwr0), .m_paddr(pa0), .m_pwdata(pwd0), .m_prdata(m_prdata)
    );
    spi_flash_rd_seq #(.POLL_MAX(16'd4)) dut1 (
        .apb_pclk(clk), .apb_prst(rst), .req(req1), .req_addr(req_addr), .req_len(req_len),
        .busy(busy1), .rd_data(rd1), .rd_valid(rv1), .done(done1), .err(err1),
        .m_psel(psel1), .m_penable(pen1), .m_pwrite(pwr1), .m_paddr(pa1), .m_pwdata(pwd1), .m_prdata(m_prdata)
    );

    assign psel = use1 ? psel1 : psel0;
    assign pen  = use1 ? pen1 : pen0;
    assign pwr  = use1 ? pwr1 : pwr0;
    assign pa   = use1 ? pa1 : pa0;
    assign pwd  = use1 ? pwd1 : pwd0;
    assign busy = use1 ? busy1 : busy0;
    assign rv   = use1 ? rv1 : rv0;
    assign rd   = use1 ? rd1 : rd0;
    assign done = use1 ? done1 : done0;
    assign err  = use1 ? err1 : err0;

    // controller model: registered APB slave, rfempty held for 'hold' polls after each TXDATA write
    always @(posedge clk) begin
        if (psel && pen) begin
            if (pwr && pa == 4'd0)
                tx_n <= 0;
            if (pwr && pa == 4'd2) begin
                tx_n    <= tx_n + 1;
                last_tx <= pwd;
                polls   <= 0;
            end
            if (!pwr && pa == 4'd1) begin
                m_prdata <= {7'd0, never || polls < hold};
                polls    <= polls + 1;
            end
            if (!pwr && pa == 4'd2)
                m_prdata <= use_tab ? tab[(tx_n - 1) & 7] : ~last_tx;
        end
    end

    always @(negedge clk) begin
        if (psel && pen && pwr) begin
            wl[nw & 1023] = {pa, pwd};
            if (pa == 4'd0) nspcr++;
            if (pa == 4'd2) ntx++;
            if (pa == 4'd5 && pwd == 8'hF0) ntx_f0 = ntx;
            nw++;
        end
        if (psel && pen && !pwr && pa == 4'd1) nspsr++;
        if (psel && pen && !pwr && pa == 4'd2) nrx++;
        if (rv) begin
            rvd[nrv & 1023]  = rd;
            rvtx[nrv & 1023] = ntx;
            nrv++;
        end
        if (done) ndone++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input bit which, input logic [23:0] a, input logic [7:0] l);
        @(negedge clk);
        req_addr = a;
        req_len  = l;
        if (which) req1 = 1'b1;
        else req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output logic e);
        bit seen = 0;
        e = 1'bx;
        for (int c = 0; c < maxc && !seen; c++) begin
            @(negedge clk);
            seen = done;
        end
        chk("done_seen", seen, 1);
        if (seen) begin
            chk("busy_at_done", busy, 0);
            e = err;
        end
        @(negedge clk);
    endtask

    initial begin
        int bw, btx, bsp, brx, brv, bd, bc;
        logic e;
        bit hit;
        for (int i = 0; i < 8; i++) tab[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_psel", psel0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_outs", {pen0, pwr0, done0, err0, rv0, rd0, pa0, pwd0}, 0);
        chk("rst_outs1", {psel1, busy1, done1, err1, rv1}, 0);
        rst = 1'b0;

        bw = nw; bsp = nspsr; brx = nrx; brv = nrv; bd = ndone;
        start(0, 24'h123456, 8'd1);
        chk("t1_busy", busy0, 1);
        wait_done(300, e);
        chk("t1_err", e, 0);
        chk("t1_nwr", nw - bw, 9);
        for (int i = 0; i < 9; i++) chk($sformatf("t1_wr%0d", i), wl[bw + i], exp1[i]);
        chk("t1_nspsr", nspsr - bsp, 5);
        chk("t1_nrx", nrx - brx, 5);
        chk("t1_nrv", nrv - brv, 1);
        chk("t1_rd", rvd[brv], 8'hFF);
        chk("t1_ndone", ndone - bd, 1);
        chk("t1_idle", busy0, 0);

        hold = 3; use_tab = 1'b1; tab[4] = 8'hA5; tab[5] = 8'h5A;
        btx = ntx; bsp = nspsr; brv = nrv; bd = ndone;
        start(0, 24'h000100, 8'd2);
        wait_done(600, e);
        chk("t2_err", e, 0);
        chk("t2_nspsr", nspsr - bsp, 24);
        chk("t2_nrv", nrv - brv, 2);
        chk("t2_rd0", rvd[brv], 8'hA5);
        chk("t2_rd1", rvd[brv + 1], 8'h5A);
        chk("t2_first_rv_tx", rvtx[brv] - btx, 5);
        chk("t2_ndone", ndone - bd, 1);
        hold = 0; use_tab = 1'b0;

        bw = nw; btx = ntx; brv = nrv; bd = ndone;
        start(0, 24'hABCDEF, 8'd0);
        wait_done(4000, e);
        chk("t3_err", e, 0);
        chk("t3_nrv", nrv - brv, 256);
        chk("t3_ntx", ntx - btx, 260);
        chk("t3_tx_before_off", ntx_f0 - btx, 260);
        chk("t3_addr_hi", wl[bw + 4], 12'h2AB);
        chk("t3_last_rd", rvd[(nrv - 1) & 1023], 8'hFF);
        chk("t3_last_wr", wl[(nw - 1) & 1023], 12'h5F0);
        chk("t3_ndone", ndone - bd, 1);

        use1 = 1'b1; never = 1'b1;
        bw = nw; bsp = nspsr; brv = nrv; bd = ndone;
        start(1, 24'h000001, 8'd1);
        wait_done(200, e);
        chk("t4_err", e, 1);
        chk("t4_nspsr", nspsr - bsp, 4);
        chk("t4_nwr", nw - bw, 5);
        chk("t4_tx", wl[bw + 3], 12'h203);
        chk("t4_cs_off", wl[(nw - 1) & 1023], 12'h5F0);
        chk("t4_nrv", nrv - brv, 0);
        chk("t4_ndone", ndone - bd, 1);
        use1 = 1'b0; never = 1'b0;

        bd = ndone; bc = nspcr;
        start(0, 24'h000020, 8'd1);
        repeat (5) @(negedge clk);
        req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        wait_done(300, e);
        chk("t5_ndone", ndone - bd, 1);
        chk("t5_nspcr", nspcr - bc, 1);
        req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        chk("t5_busy_after", busy0, 1);
        wait_done(300, e);
        chk("t5_ndone2", ndone - bd, 2);
        chk("t5_nspcr2", nspcr - bc, 2);

        never = 1'b1;
        start(0, 24'h000030, 8'd1);
        hit = 0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk);
            hit = psel0 && !pwr0 && pa0 == 4'd1;
        end
        chk("t6_in_poll", hit, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_psel", psel0, 0);
        chk("t6_busy", busy0, 0);
        chk("t6_done", done0, 0);
        rst = 1'b0; never = 1'b0;
        bw = nw; bd = ndone;
        start(0, 24'h000040, 8'd1);
        wait_done(300, e);
        chk("t6_err", e, 0);
        chk("t6_first_wr", wl[bw & 1023], 12'h050);
        chk("t6_ndone", ndone - bd, 1);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end
endmodule
